// File: rtl/nfa_pkg.sv
// nfa_pkg
// Shared definitions for the NFA chain engine:
//   - default sizes and the widths derived from them (class index,
//     state address, pattern length)
//   - mode encodings for the ANCHOR and STICKY parameters
//   - the program-table entry layout (class index + self-loop flag)
package nfa_pkg;

   localparam int NCLS_DFLT  = 32;
   localparam int DEPTH_DFLT = 16;
   localparam int POSW_DFLT  = 16;

   localparam int CLS_W  = $clog2(NCLS_DFLT);
   localparam int ADDR_W = $clog2(DEPTH_DFLT);
   localparam int LEN_W  = ADDR_W + 1;

   localparam logic ANCHOR_ANY   = 1'b0;  // a match may begin on any byte
   localparam logic ANCHOR_SOD   = 1'b1;  // a match may only begin on the first byte after sod
   localparam logic STICKY_PULSE = 1'b0;  // out pulses once per match
   localparam logic STICKY_LATCH = 1'b1;  // out latches on the first match until sod

   typedef struct packed {
      logic [CLS_W-1:0] cls;
      logic             loop;
   } prog_entry_t;

endpackage

// File: rtl/nfa_state_cell.sv
// nfa_state_cell
// One state bit of the pattern chain. The state is active after a byte when
// the byte hits this state's class and either the predecessor was active or
// this state loops on itself and was active.
// Ports:
//   clk      clock
//   sod      synchronous clear (start of data)
//   en       byte-valid strobe; the bit holds when low
//   cls_hit  class hit for this state's programmed class
//   pred     predecessor state (or the start term for state 0)
//   loop     self-loop flag
//   keep     state index is inside the active pattern length
//   s_d      next-state value (used for match detection on the last state)
//   s_q      registered state bit
module nfa_state_cell (
   input  logic clk,
   input  logic sod,
   input  logic en,
   input  logic cls_hit,
   input  logic pred,
   input  logic loop,
   input  logic keep,
   output logic s_d,
   output logic s_q
);

   assign s_d = keep & cls_hit & (pred | (loop & s_q));

   always_ff @(posedge clk) begin
      if (sod) begin
         s_q <= 1'b0;
      end else if (en) begin
         s_q <= s_d;
      end
   end

endmodule

// File: rtl/nfa_chain_engine.sv
// nfa_chain_engine
// Runs a programmable linear NFA (a chain of up to DEPTH states, each with a
// character class and an optional '+' self-loop) over a byte stream given as
// pre-decoded class hit lines. Reports matches through a registered out flag,
// a one-entry position report with ready handshake, a saturating match counter
// and a sticky overflow flag.
// Ports:
//   clk                  clock
//   sod                  synchronous reset / start of data
//   en, cls              byte-valid strobe and class hits for the byte
//   prog_we, prog_addr,
//   prog_cls, prog_loop,
//   prog_len             program-table write (only accepted while en=0)
//   prog_err             one-cycle pulse when a write collides with en=1
//   out                  match indication (latched or pulsed, see STICKY)
//   hit_valid, hit_ready,
//   hit_pos              match report and consumer handshake
//   match_cnt            saturating match count
//   ovf                  sticky flag: a report was dropped
module nfa_chain_engine
   import nfa_pkg::*;
#(
   parameter int   NCLS   = NCLS_DFLT,
   parameter int   DEPTH  = DEPTH_DFLT,
   parameter logic ANCHOR = ANCHOR_ANY,
   parameter logic STICKY = STICKY_LATCH,
   parameter int   POSW   = POSW_DFLT
) (
   input  logic                       clk,
   input  logic                       sod,
   input  logic                       en,
   input  logic [NCLS-1:0]            cls,
   input  logic                       prog_we,
   input  logic [$clog2(DEPTH)-1:0]   prog_addr,
   input  logic [$clog2(NCLS)-1:0]    prog_cls,
   input  logic                       prog_loop,
   input  logic [$clog2(DEPTH):0]     prog_len,
   output logic                       prog_err,
   output logic                       out,
   output logic                       hit_valid,
   input  logic                       hit_ready,
   output logic [POSW-1:0]            hit_pos,
   output logic [POSW-1:0]            match_cnt,
   output logic                       ovf
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam logic [POSW-1:0] POS_MAX = '1;

   prog_entry_t     tbl [DEPTH];
   logic [LW-1:0]   len_q;
   logic            prog_ok;
   logic            seen_q;
   logic            start;
   logic [DEPTH-1:0] s_q;
   logic [DEPTH-1:0] s_d;
   logic [DEPTH-1:0] cls_hit;
   logic [DEPTH-1:0] keep;
   logic [DEPTH-1:0] pred;
   logic            evt;
   logic [POSW-1:0] pos_q;

   // The table is configuration, not data-path state: sod leaves it alone,
   // and a write that collides with a live byte is dropped.
   assign prog_ok = prog_we & ~en & ~sod;

   always_ff @(posedge clk) begin
      if (prog_ok) begin
         tbl[prog_addr] <= '{cls: prog_cls, loop: prog_loop};
         len_q          <= prog_len;
      end
   end

   always_ff @(posedge clk) begin
      if (sod) begin
         prog_err <= 1'b0;
      end else begin
         prog_err <= prog_we & en;
      end
   end

   // seen_q marks that the first byte after sod has gone by; in anchored
   // mode only that byte may enter state 0 from outside the chain.
   always_ff @(posedge clk) begin
      if (sod) begin
         seen_q <= 1'b0;
      end else if (en) begin
         seen_q <= 1'b1;
      end
   end

   assign start = (ANCHOR == ANCHOR_SOD) ? ~seen_q : 1'b1;

   for (genvar i = 0; i < DEPTH; i++) begin : g_cell
      localparam logic [LW-1:0] IDX = LW'(i);

      assign cls_hit[i] = cls[tbl[i].cls];
      assign keep[i]    = (IDX < len_q);

      if (i == 0) begin : g_head
         assign pred[i] = start;
      end else begin : g_link
         assign pred[i] = s_q[i-1];
      end

      nfa_state_cell u_cell (
         .clk     (clk),
         .sod     (sod),
         .en      (en),
         .cls_hit (cls_hit[i]),
         .pred    (pred[i]),
         .loop    (tbl[i].loop),
         .keep    (keep[i]),
         .s_d     (s_d[i]),
         .s_q     (s_q[i])
      );
   end

   // Match event: the last active state becomes set by this byte. A length
   // of 0 or beyond DEPTH selects no state and so never matches.
   always_comb begin
      evt = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (len_q == LW'(i + 1)) begin
            evt = en & s_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sod) begin
         pos_q     <= '0;
         out       <= 1'b0;
         hit_valid <= 1'b0;
         hit_pos   <= '0;
         match_cnt <= '0;
         ovf       <= 1'b0;
      end else begin
         if (en && (pos_q != POS_MAX)) begin
            pos_q <= pos_q + 1'b1;
         end

         if (STICKY == STICKY_LATCH) begin
            out <= out | evt;
         end else begin
            out <= evt;
         end

         if (evt && (match_cnt != POS_MAX)) begin
            match_cnt <= match_cnt + 1'b1;
         end

         // A pending report is never overwritten unless the consumer takes
         // it in the same cycle; otherwise the new one is dropped and flagged.
         if (evt) begin
            if (!hit_valid || hit_ready) begin
               hit_pos   <= pos_q;
               hit_valid <= 1'b1;
            end else begin
               ovf <= 1'b1;
            end
         end else if (hit_valid && hit_ready) begin
            hit_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nfa_chain_engine.sv
// Directed bench for nfa_chain_engine. Four instances share one stimulus
// stream: u0 unanchored/latched, u1 anchored/latched, u2 unanchored/pulsed,
// u3 unanchored/latched with 4-bit position and count registers.
// Class lines used: 'a'=0, 'b'=1, 'c'=2, anything else=5.
module tb_nfa_chain_engine;

   logic        clk = 1'b0;
   logic        sod;
   logic        en;
   logic [31:0] cls;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [4:0]  prog_cls;
   logic        prog_loop;
   logic [4:0]  prog_len;
   logic        hit_ready;

   logic        prog_err_0, out_0, hit_valid_0, ovf_0;
   logic [15:0] hit_pos_0, match_cnt_0;
   logic        prog_err_1, out_1, hit_valid_1, ovf_1;
   logic [15:0] hit_pos_1, match_cnt_1;
   logic        prog_err_2, out_2, hit_valid_2, ovf_2;
   logic [15:0] hit_pos_2, match_cnt_2;
   logic        prog_err_3, out_3, hit_valid_3, ovf_3;
   logic [3:0]  hit_pos_3, match_cnt_3;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   nfa_chain_engine #(.NCLS(32), .DEPTH(16), .ANCHOR(1'b0), .STICKY(1'b1), .POSW(16)) u0 (
      .clk(clk), .sod(sod), .en(en), .cls(cls), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_cls(prog_cls), .prog_loop(prog_loop), .prog_len(prog_len), .prog_err(prog_err_0),
      .out(out_0), .hit_valid(hit_valid_0), .hit_ready(hit_ready), .hit_pos(hit_pos_0),
      .match_cnt(match_cnt_0), .ovf(ovf_0));

   nfa_chain_engine #(.NCLS(32), .DEPTH(16), .ANCHOR(1'b1), .STICKY(1'b1), .POSW(16)) u1 (
      .clk(clk), .sod(sod), .en(en), .cls(cls), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_cls(prog_cls), .prog_loop(prog_loop), .prog_len(prog_len), .prog_err(prog_err_1),
      .out(out_1), .hit_valid(hit_valid_1), .hit_ready(hit_ready), .hit_pos(hit_pos_1),
      .match_cnt(match_cnt_1), .ovf(ovf_1));

   nfa_chain_engine #(.NCLS(32), .DEPTH(16), .ANCHOR(1'b0), .STICKY(1'b0), .POSW(16)) u2 (
      .clk(clk), .sod(sod), .en(en), .cls(cls), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_cls(prog_cls), .prog_loop(prog_loop), .prog_len(prog_len), .prog_err(prog_err_2),
      .out(out_2), .hit_valid(hit_valid_2), .hit_ready(hit_ready), .hit_pos(hit_pos_2),
      .match_cnt(match_cnt_2), .ovf(ovf_2));

   nfa_chain_engine #(.NCLS(32), .DEPTH(16), .ANCHOR(1'b0), .STICKY(1'b1), .POSW(4)) u3 (
      .clk(clk), .sod(sod), .en(en), .cls(cls), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_cls(prog_cls), .prog_loop(prog_loop), .prog_len(prog_len), .prog_err(prog_err_3),
      .out(out_3), .hit_valid(hit_valid_3), .hit_ready(hit_ready), .hit_pos(hit_pos_3),
      .match_cnt(match_cnt_3), .ovf(ovf_3));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] onehot(input byte ch);
      logic [31:0] v;
      v = 32'd1;
      case (ch)
         "a":     return v << 0;
         "b":     return v << 1;
         "c":     return v << 2;
         default: return v << 5;
      endcase
   endfunction

   task automatic feed(input byte ch);
      en  = 1'b1;
      cls = onehot(ch);
      step();
      en  = 1'b0;
      cls = '0;
   endtask

   task automatic feed_str(input string s);
      for (int i = 0; i < s.len(); i++) feed(s[i]);
   endtask

   task automatic do_sod();
      sod = 1'b1;
      step();
      sod = 1'b0;
   endtask

   task automatic prog(input logic [3:0] a, input logic [4:0] c, input logic l, input logic [4:0] len);
      prog_we   = 1'b1;
      prog_addr = a;
      prog_cls  = c;
      prog_loop = l;
      prog_len  = len;
      step();
      prog_we   = 1'b0;
   endtask

   initial begin
      sod = 1'b1; en = 1'b0; cls = '0; prog_we = 1'b0; prog_addr = '0;
      prog_cls = '0; prog_loop = 1'b0; prog_len = '0; hit_ready = 1'b0;

      // Reset state
      step();
      sod = 1'b0;
      check("rst_out",       out_0,       0);
      check("rst_hit_valid", hit_valid_0, 0);
      check("rst_hit_pos",   hit_pos_0,   0);
      check("rst_match_cnt", match_cnt_0, 0);
      check("rst_ovf",       ovf_0,       0);
      check("rst_prog_err",  prog_err_0,  0);

      // Program "abc"
      prog(4'd0, 5'd0, 1'b0, 5'd3);
      prog(4'd1, 5'd1, 1'b0, 5'd3);
      prog(4'd2, 5'd2, 1'b0, 5'd3);
      check("prog_no_err", prog_err_0, 0);

      // "xxabc": unanchored matches at pos 4, anchored does not
      do_sod();
      feed_str("xxab");
      check("abc_before_c", out_0, 0);
      feed("c");
      check("abc_out",       out_0,       1);
      check("abc_hit_pos",   hit_pos_0,   4);
      check("abc_match_cnt", match_cnt_0, 1);
      check("abc_hit_valid", hit_valid_0, 1);
      check("anc_no_evt",    out_1,       0);
      check("anc_no_cnt",    match_cnt_1, 0);
      check("pulse_out",     out_2,       1);
      step();
      check("sticky_hold",   out_0,       1);
      check("pulse_drop",    out_2,       0);

      // Anchored pattern at the very first byte
      do_sod();
      feed_str("abc");
      check("anc_out",     out_1,     1);
      check("anc_hit_pos", hit_pos_1, 2);

      // sod together with en and prog_we in the middle of a pattern
      feed_str("ab");
      sod = 1'b1; en = 1'b1; cls = onehot("c");
      prog_we = 1'b1; prog_addr = 4'd1; prog_cls = 5'd7; prog_loop = 1'b1; prog_len = 5'd1;
      step();
      sod = 1'b0; en = 1'b0; cls = '0; prog_we = 1'b0;
      check("sod_out",       out_0,       0);
      check("sod_hit_valid", hit_valid_0, 0);
      check("sod_hit_pos",   hit_pos_0,   0);
      check("sod_match_cnt", match_cnt_0, 0);
      check("sod_prog_err",  prog_err_0,  0);
      feed("c");
      check("sod_partial_dropped", out_0, 0);
      feed_str("abc");
      check("sod_prog_kept_pos", hit_pos_0,   3);
      check("sod_prog_kept_cnt", match_cnt_0, 1);

      // prog_we during a live byte is rejected
      do_sod();
      en = 1'b1; cls = onehot("a");
      prog_we = 1'b1; prog_addr = 4'd0; prog_cls = 5'd7; prog_loop = 1'b0; prog_len = 5'd1;
      step();
      en = 1'b0; cls = '0; prog_we = 1'b0;
      check("perr_pulse", prog_err_0, 1);
      step();
      check("perr_clear", prog_err_0, 0);
      feed_str("bc");
      check("perr_tbl_pos", hit_pos_0,   2);
      check("perr_tbl_cnt", match_cnt_0, 1);

      // "ab+c" on the pulsed instance
      prog(4'd1, 5'd1, 1'b1, 5'd3);
      do_sod();
      begin
         string s;
         s = "abbbcac";
         for (int i = 0; i < s.len(); i++) begin
            feed(s[i]);
            check($sformatf("loop_pulse_b%0d", i), out_2, (i == 4) ? 1 : 0);
         end
      end
      check("loop_match_cnt", match_cnt_2, 1);
      check("loop_hit_pos",   hit_pos_2,   4);

      // Report overflow with the consumer stalled
      prog(4'd1, 5'd1, 1'b0, 5'd3);
      do_sod();
      hit_ready = 1'b0;
      feed_str("abcabc");
      check("ovf_hit_pos",   hit_pos_0,   2);
      check("ovf_flag",      ovf_0,       1);
      check("ovf_match_cnt", match_cnt_0, 2);
      check("ovf_hit_valid", hit_valid_0, 1);
      hit_ready = 1'b1;
      step();
      check("hs_clear", hit_valid_0, 0);
      hit_ready = 1'b0;
      feed_str("abcab");
      hit_ready = 1'b1;
      feed("c");
      hit_ready = 1'b0;
      check("hs_evt_pos",   hit_pos_0,   11);
      check("hs_evt_valid", hit_valid_0, 1);
      check("hs_evt_cnt",   match_cnt_0, 4);

      // Saturation with 4-bit registers, pattern "a"
      prog(4'd0, 5'd0, 1'b0, 5'd1);
      do_sod();
      hit_ready = 1'b1;
      for (int i = 0; i < 20; i++) feed("a");
      hit_ready = 1'b0;
      check("sat_match_cnt", match_cnt_3, 15);
      check("sat_hit_pos",   hit_pos_3,   15);
      check("sat_ovf",       ovf_3,       0);
      check("wide_match_cnt", match_cnt_0, 20);
      check("wide_hit_pos",   hit_pos_0,   19);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
